// File: rtl/cam_sccb_init_seq.sv
// ---------------------------------------------------------------------------
// cam_sccb_init_seq
//
// Camera bring-up sequencer. After an accepted start it writes the sensor
// soft-reset register (0x12 <= 0x80), waits for the sensor to settle, then
// walks a config ROM of {reg,val} pairs. Each pair becomes one SCCB register
// write through a req/ack handshake with the SCCB byte-level master. The walk
// ends when it reads the 16'hFFFF terminator or finishes the last ROM entry.
// The sticky done flag gates the downstream frame store/read FSMs.
//
// Optional feature macro: SCCB_RETRY_EN
//   defined   : a NACKed register write is re-issued after a GAP, up to
//               MAX_RETRY times. The next NACK after that raises error.
//   undefined : any NACK on a config write raises error immediately.
//
// Ports
//   sys_clk    in   system clock
//   rst_n      in   asynchronous active-low reset
//   start      in   1-cycle pulse that starts a sequence; ignored while busy
//   busy       out  sequence in progress
//   done       out  sticky: sequence completed
//   error      out  sticky: a register write failed
//   rom_addr   out  config ROM address (ROM_AW bits)
//   rom_data   in   {reg,val} from a synchronous ROM, valid 1 cycle after addr
//   sccb_req   out  write request to the SCCB master
//   sccb_reg   out  register address, frozen while sccb_req=1
//   sccb_val   out  register value, frozen while sccb_req=1
//   sccb_ack   in   1-cycle pulse: write acknowledged
//   sccb_nack  in   1-cycle pulse: write not acknowledged (wins over ack)
//   fail_addr  out  register address of the last failed write
// ---------------------------------------------------------------------------
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start
// RST_REQ  | soft-reset write 0x12 <= 0x80 in flight (NACK tolerated)
// RST_WAIT | sensor settle time after soft reset
// FETCH    | ROM address = idx
// LATCH    | ROM data valid; latch pair or detect terminator
// ISSUE    | config write in flight
// GAP      | idle spacing between writes (also before a retry)
// DONE     | sequence finished, done set
// ERR      | write failed, error set
module cam_sccb_init_seq #(
    parameter int SYS_CLK_FREQ  = 100_000_000,
    parameter int ROM_AW        = 8,
    parameter int RESET_WAIT_US = 20000,
    parameter int GAP_CYCLES    = 16,
    parameter int MAX_RETRY     = 3
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sccb_req,
    output logic [7:0]        sccb_reg,
    output logic [7:0]        sccb_val,
    input  logic              sccb_ack,
    input  logic              sccb_nack,
    output logic [7:0]        fail_addr
);

    localparam int WAIT_N = SYS_CLK_FREQ / 1_000_000 * RESET_WAIT_US;
    localparam int WAIT_W = $clog2(WAIT_N + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int TMR_W  = (WAIT_W > GAP_W) ? WAIT_W : GAP_W;

    // The timer is loaded with N-1 on entry so the state lasts exactly N cycles.
    localparam logic [TMR_W-1:0]  WAIT_LD  = TMR_W'(WAIT_N - 1);
    localparam logic [TMR_W-1:0]  GAP_LD   = TMR_W'(GAP_CYCLES - 1);
    localparam logic [ROM_AW-1:0] IDX_LAST = '1;
    localparam logic [15:0]       ROM_TERM = 16'hFFFF;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RST_REQ  = 4'd1,
        RST_WAIT = 4'd2,
        FETCH    = 4'd3,
        LATCH    = 4'd4,
        ISSUE    = 4'd5,
        GAP      = 4'd6,
        DONE     = 4'd7,
        ERR      = 4'd8
    } state_t;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   tmr;
    logic [ROM_AW-1:0]  idx;

    logic hs;
    logic start_acc;
    logic tmr_load_wait;
    logic tmr_load_gap;
    logic idx_inc;
    logic retry_now;

    // A handshake only counts while a request is actually on the bus.
    assign hs       = sccb_req && (sccb_ack || sccb_nack);
    assign rom_addr = idx;

`ifdef SCCB_RETRY_EN
    localparam int               RW        = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0]    RETRY_LIM = RW'(MAX_RETRY);

    logic [RW-1:0] retry_cnt;
    logic          retry_pend;

    assign retry_now = retry_pend;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
        end else begin
            if (start_acc || state == LATCH) begin
                retry_cnt <= '0;
            end else if (state == ISSUE && hs) begin
                if (sccb_nack) begin
                    retry_cnt <= retry_cnt + RW'(1);
                end else begin
                    retry_cnt <= '0;
                end
            end

            if (start_acc) begin
                retry_pend <= 1'b0;
            end else if (state == ISSUE && hs && sccb_nack && state_nxt == GAP) begin
                retry_pend <= 1'b1;
            end else if (state == GAP && tmr == '0) begin
                retry_pend <= 1'b0;
            end
        end
    end
`else
    localparam int unused_max_retry = MAX_RETRY;

    assign retry_now = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        start_acc     = 1'b0;
        tmr_load_wait = 1'b0;
        tmr_load_gap  = 1'b0;
        idx_inc       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = RST_REQ;
                end
            end
            RST_REQ: begin
                if (hs) begin
                    tmr_load_wait = 1'b1;
                    state_nxt     = RST_WAIT;
                end
            end
            RST_WAIT: begin
                if (tmr == '0) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = LATCH;
            end
            LATCH: begin
                state_nxt = (rom_data == ROM_TERM) ? DONE : ISSUE;
            end
            ISSUE: begin
                if (hs) begin
                    if (sccb_nack) begin
`ifdef SCCB_RETRY_EN
                        state_nxt = (retry_cnt >= RETRY_LIM) ? ERR : GAP;
`else
                        state_nxt = ERR;
`endif
                    end else begin
                        state_nxt = GAP;
                    end
                    tmr_load_gap = (state_nxt == GAP);
                end
            end
            GAP: begin
                if (tmr == '0) begin
                    if (retry_now) begin
                        state_nxt = ISSUE;
                    end else if (idx == IDX_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        idx_inc   = 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            ERR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr       <= '0;
            idx       <= '0;
            sccb_req  <= 1'b0;
            sccb_reg  <= 8'h00;
            sccb_val  <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            fail_addr <= 8'h00;
        end else begin
            // Request rises one cycle after entering RST_REQ/ISSUE and drops
            // on the cycle following the handshake, since the state moves on.
            sccb_req <= (state == RST_REQ || state == ISSUE) && (state_nxt == state);

            if (tmr_load_wait) begin
                tmr <= WAIT_LD;
            end else if (tmr_load_gap) begin
                tmr <= GAP_LD;
            end else if (tmr != '0) begin
                tmr <= tmr - TMR_W'(1);
            end

            if (start_acc) begin
                busy     <= 1'b1;
                done     <= 1'b0;
                error    <= 1'b0;
                idx      <= '0;
                sccb_reg <= 8'h12;
                sccb_val <= 8'h80;
            end

            if (state == LATCH && rom_data != ROM_TERM) begin
                sccb_reg <= rom_data[15:8];
                sccb_val <= rom_data[7:0];
            end

            if (idx_inc) begin
                idx <= idx + ROM_AW'(1);
            end

            if (state_nxt == DONE) begin
                done <= 1'b1;
                busy <= 1'b0;
            end

            if (state_nxt == ERR) begin
                error     <= 1'b1;
                busy      <= 1'b0;
                fail_addr <= sccb_reg;
            end
        end
    end

endmodule

// File: tb/tb_cam_sccb_init_seq.sv
module tb_cam_sccb_init_seq;

    localparam int WAIT_N = 100;   // 100 MHz * 1 us
    localparam int GAP    = 16;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic        busy, done, error;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic        sccb_req;
    logic [7:0]  sccb_reg, sccb_val;
    logic        sccb_ack  = 1'b0;
    logic        sccb_nack = 1'b0;
    logic [7:0]  fail_addr;

    cam_sccb_init_seq #(
        .SYS_CLK_FREQ (100_000_000),
        .ROM_AW       (8),
        .RESET_WAIT_US(1),
        .GAP_CYCLES   (GAP),
        .MAX_RETRY    (3)
    ) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .sccb_req (sccb_req),
        .sccb_reg (sccb_reg),
        .sccb_val (sccb_val),
        .sccb_ack (sccb_ack),
        .sccb_nack(sccb_nack),
        .fail_addr(fail_addr)
    );

    always #5 sys_clk = ~sys_clk;

    logic [15:0] rom_mem [256];
    always @(posedge sys_clk) rom_data <= rom_mem[rom_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: the stimulus pushes expected {reg,val}; the monitor pops on
    // every new request and also plays the SCCB master (ack/nack responder).
    logic [15:0] exp_q[$];
    int          low_q[$];
    int          req_cnt   = 0;
    int          low_run   = 0;
    int          resp_dly  = 0;
    int          nack_left = 0;
    int          nack_rst  = 0;
    logic [7:0]  nack_reg  = 8'h00;
    logic        req_seen  = 1'b0;
    int          hold      = 0;
    logic [15:0] cur       = 16'h0000;

    always @(negedge sys_clk) begin
        sccb_ack  = 1'b0;
        sccb_nack = 1'b0;
        if (!rst_n) begin
            req_seen = 1'b0;
            low_run  = 0;
        end else if (sccb_req) begin
            if (!req_seen) begin
                req_seen = 1'b1;
                hold     = 0;
                cur      = {sccb_reg, sccb_val};
                req_cnt++;
                low_q.push_back(low_run);
                low_run = 0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: got %h, expected no request", cur);
                end else begin
                    check("sccb_write", cur, exp_q.pop_front());
                end
            end else begin
                check("req_hold_stable", {sccb_reg, sccb_val}, cur);
                hold++;
            end
            if (hold >= resp_dly) begin
                if (cur == 16'h1280 && nack_rst > 0) begin
                    sccb_nack = 1'b1;
                    nack_rst--;
                end else if (cur[15:8] == nack_reg && nack_left > 0) begin
                    sccb_nack = 1'b1;
                    nack_left--;
                end else begin
                    sccb_ack = 1'b1;
                end
            end
        end else begin
            req_seen = 1'b0;
            if (busy) low_run++;
            else      low_run = 0;
        end
    end

    task automatic pulse_start();
        @(negedge sys_clk) start = 1'b1;
        @(negedge sys_clk) start = 1'b0;
    endtask

    task automatic do_start();
        pulse_start();
        check("start_busy", busy, 1);
        check("start_done_clr", done, 0);
        check("start_err_clr", error, 0);
    endtask

    task automatic wait_end(input int lim);
        int n = 0;
        while (!(done || error) && n < lim) begin
            @(negedge sys_clk);
            n++;
        end
        check("seq_finished_in_time", done | error, 1);
        @(negedge sys_clk);
    endtask

    task automatic rom_basic();
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
        rom_mem[0] = 16'h1234;
        rom_mem[1] = 16'h5678;
    endtask

    int base, lb;

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
        repeat (3) @(negedge sys_clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_req", sccb_req, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_fail_addr", fail_addr, 0);
        check("rst_reg_val", {sccb_reg, sccb_val}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Basic ROM, delayed ack, stray start during the settle wait.
        rom_basic();
        resp_dly = 2;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h5678);
        base = req_cnt;
        lb   = low_q.size();
        do_start();
        repeat (20) @(negedge sys_clk);
        pulse_start();
        check("busy_after_stray_start", busy, 1);
        wait_end(2000);
        check("basic_done", done, 1);
        check("basic_error", error, 0);
        check("basic_busy", busy, 0);
        check("basic_req_count", req_cnt - base, 3);
        check("basic_queue_empty", exp_q.size(), 0);
        check("basic_rom_addr_end", rom_addr, 2);
        check("lat_start_to_req", low_q[lb], 1);
        check("lat_reset_wait", low_q[lb+1], WAIT_N + 3);
        check("lat_gap", low_q[lb+2], GAP + 3);

        // Full ROM, no terminator.
        resp_dly = 0;
        exp_q.push_back(16'h1280);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            rom_mem[i] = {b, ~b};
            exp_q.push_back({b, ~b});
        end
        base = req_cnt;
        do_start();
        wait_end(20000);
        check("full_done", done, 1);
        check("full_error", error, 0);
        check("full_req_count", req_cnt - base, 257);
        check("full_idx_stop", rom_addr, 8'hFF);
        check("full_queue_empty", exp_q.size(), 0);

        // NACK on entry 2 (reg 3A); soft-reset NACK tolerated.
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
        rom_mem[0] = 16'h1234;
        rom_mem[1] = 16'h3A55;
        rom_mem[2] = 16'h5678;
        nack_reg = 8'h3A;
        nack_rst = 1;
`ifndef SCCB_RETRY_EN
        nack_left = 1;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h3A55);
        base = req_cnt;
        do_start();
        wait_end(2000);
        check("nack_error", error, 1);
        check("nack_done", done, 0);
        check("nack_busy", busy, 0);
        check("nack_fail_addr", fail_addr, 8'h3A);
        repeat (200) @(negedge sys_clk);
        check("nack_no_more_req", req_cnt - base, 3);
        check("nack_queue_empty", exp_q.size(), 0);
`else
        nack_left = 3;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1234);
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h3A55);
        exp_q.push_back(16'h5678);
        base = req_cnt;
        lb   = low_q.size();
        do_start();
        wait_end(3000);
        check("retry_done", done, 1);
        check("retry_error", error, 0);
        check("retry_req_count", req_cnt - base, 7);
        check("retry_gap", low_q[lb+3], GAP + 1);
        check("retry_queue_empty", exp_q.size(), 0);

        nack_left = 4;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1234);
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h3A55);
        base = req_cnt;
        do_start();
        wait_end(3000);
        check("retry_exh_error", error, 1);
        check("retry_exh_done", done, 0);
        check("retry_exh_fail_addr", fail_addr, 8'h3A);
        repeat (200) @(negedge sys_clk);
        check("retry_exh_req_count", req_cnt - base, 6);
        check("retry_exh_queue_empty", exp_q.size(), 0);
`endif
        nack_left = 0;
        nack_rst  = 0;

        // Reset while a request is pending, then restart from the soft reset.
        rom_basic();
        resp_dly = 1000;
        exp_q.push_back(16'h1280);
        do_start();
        begin
            int n = 0;
            while (!sccb_req && n < 20) begin
                @(negedge sys_clk);
                n++;
            end
        end
        check("req_before_reset", sccb_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_drops_req", sccb_req, 0);
        check("reset_drops_busy", busy, 0);
        check("reset_clears_error", error, 0);
        @(negedge sys_clk) rst_n = 1'b1;
        resp_dly = 0;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h5678);
        base = req_cnt;
        do_start();
        wait_end(2000);
        check("restart_done", done, 1);
        check("restart_req_count", req_cnt - base, 3);
        check("restart_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
